morse_key_timing: RTL and testbench

Front-end stage of the Morse receive path. It conditions a raw telegraph-key level, measures mark and space durations in clock cycles, and classifies each mark as dot or dash. It emits one-cycle symbol strobes plus character-end and word-end strobes, which directly feed the downstream Morse symbol decoder. Symbol encoding matches the decoder: 1 = dot, 0 = dash.

---
 rtl/morse_pkg.sv | 16 +
 rtl/morse_key_cond.sv | 69 ++++++
 rtl/morse_key_timing.sv | 153 +++++++++++++++
 tb/tb_morse_key_timing.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path: key timing front-end and symbol decoder.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      STUCK = 2'd3
   } morse_state_e;

   localparam logic SYM_DOT  = 1'b1;
   localparam logic SYM_DASH = 1'b0;

   localparam int unsigned MAX_SYMS = 5;

endpackage

// File: rtl/morse_key_cond.sv
// Key conditioning: 2-flop synchronizer plus an optional debouncer (MORSE_KEY_DEBOUNCE_EN).
// With the debouncer, key_c follows the synchronized level once it has held for DEBOUNCE cycles.
module morse_key_cond
`ifdef MORSE_KEY_DEBOUNCE_EN
#(
   parameter int DEBOUNCE = 3
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic key_c
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = key;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef MORSE_KEY_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0] DB_RELOAD = DB_W'(DEBOUNCE - 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            key_c_q, key_c_d;

   // Down-counter runs only while the synchronized level disagrees with key_c.
   always_comb begin
      key_c_d  = key_c_q;
      db_cnt_d = DB_RELOAD;
      if (sync2_q != key_c_q) begin
         if (db_cnt_q == '0) begin
            key_c_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_c_q  <= 1'b0;
         db_cnt_q <= DB_RELOAD;
      end else begin
         key_c_q  <= key_c_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign key_c = key_c_q;
`else
   assign key_c = sync2_q;
`endif

endmodule

// File: rtl/morse_key_timing.sv
// Morse key timing front-end: times marks and spaces on the conditioned key and emits
// symbol, character-end, word-end and error strobes. Debounce enabled by MORSE_KEY_DEBOUNCE_EN.
//
// state | meaning
// IDLE  | no activity, waiting for a press
// MARK  | key down, timing the mark
// SPACE | key up after a mark, timing the gap
// STUCK | mark reached STUCK_MAX, waiting for release
module morse_key_timing #(
   parameter int CNT_W     = 8,
   parameter int DOT_MAX   = 4,
   parameter int GAP_CHAR  = 8,
   parameter int GAP_WORD  = 20,
   parameter int STUCK_MAX = 60,
   parameter int DEBOUNCE  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   output logic       sym_valid,
   output logic       sym,
   output logic [2:0] sym_count,
   output logic       char_end,
   output logic       word_end,
   output logic       err
);
   import morse_pkg::*;

   if (!(DOT_MAX < GAP_CHAR && GAP_CHAR < GAP_WORD && GAP_WORD < STUCK_MAX &&
         STUCK_MAX <= (2 ** CNT_W) - 1 && DEBOUNCE >= 1)) begin : g_param_check
      $error("morse_key_timing: illegal parameter ordering");
   end

   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DOT_MAX_C   = CNT_W'(DOT_MAX);
   localparam logic [CNT_W-1:0] GAP_CHAR_C  = CNT_W'(GAP_CHAR);
   localparam logic [CNT_W-1:0] GAP_WORD_C  = CNT_W'(GAP_WORD);
   localparam logic [CNT_W-1:0] STUCK_MAX_C = CNT_W'(STUCK_MAX);
   localparam logic [2:0]       MAX_SYMS_C  = 3'(MAX_SYMS);

   logic key_c;

   morse_key_cond
`ifdef MORSE_KEY_DEBOUNCE_EN
   #(
      .DEBOUNCE (DEBOUNCE)
   )
`endif
   u_cond (
      .clk   (clk),
      .reset (reset),
      .key   (key),
      .key_c (key_c)
   );

   morse_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sym_valid_q, sym_valid_d;
   logic             sym_q, sym_d;
   logic [2:0]       sym_count_q, sym_count_d;
   logic             char_end_q, char_end_d;
   logic             word_end_q, word_end_d;
   logic             err_q, err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      sym_valid_d = 1'b0;
      sym_d       = sym_q;
      sym_count_d = sym_count_q;
      char_end_d  = 1'b0;
      word_end_d  = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (key_c) state_d = MARK;
         end
         MARK: begin
            if (!key_c) begin
               state_d = SPACE;
               if (sym_count_q == MAX_SYMS_C) begin
                  err_d = 1'b1;
               end else begin
                  sym_valid_d = 1'b1;
                  sym_d       = (cnt_q <= DOT_MAX_C) ? SYM_DOT : SYM_DASH;
                  sym_count_d = sym_count_q + 3'd1;
               end
            end else if (cnt_q == STUCK_MAX_C) begin
               err_d       = 1'b1;
               sym_count_d = 3'd0;
               state_d     = STUCK;
            end
         end
         SPACE: begin
            // A press on the char boundary still closes the character; on the word boundary it wins.
            if (cnt_q == GAP_CHAR_C) begin
               if (sym_count_q != 3'd0) begin
                  char_end_d  = 1'b1;
                  sym_count_d = 3'd0;
               end
               if (key_c) state_d = MARK;
            end else if (cnt_q == GAP_WORD_C) begin
               if (key_c) begin
                  state_d = MARK;
               end else begin
                  word_end_d = 1'b1;
                  state_d    = IDLE;
               end
            end else if (key_c) begin
               state_d = MARK;
            end
         end
         STUCK: begin
            if (!key_c) state_d = SPACE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) cnt_d = CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sym_valid_q <= 1'b0;
         sym_q       <= 1'b0;
         sym_count_q <= 3'd0;
         char_end_q  <= 1'b0;
         word_end_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sym_valid_q <= sym_valid_d;
         sym_q       <= sym_d;
         sym_count_q <= sym_count_d;
         char_end_q  <= char_end_d;
         word_end_q  <= word_end_d;
         err_q       <= err_d;
      end
   end

   assign sym_valid = sym_valid_q;
   assign sym       = sym_q;
   assign sym_count = sym_count_q;
   assign char_end  = char_end_q;
   assign word_end  = word_end_q;
   assign err       = err_q;

endmodule

// File: tb/tb_morse_key_timing.sv
// Bench for morse_key_timing: key run-length stimulus checked against a run-length reference model.
module tb_morse_key_timing;

   localparam int DOT_MAX   = 4;
   localparam int GAP_CHAR  = 8;
   localparam int GAP_WORD  = 20;
   localparam int STUCK_MAX = 60;
   localparam int DEBOUNCE  = 3;
   localparam int MAXSYM    = 5;
   localparam int MAXN      = 4096;

   logic       clk = 1'b0;
   logic       reset;
   logic       key;
   logic       sym_valid, sym, char_end, word_end, err;
   logic [2:0] sym_count;

   int checks = 0;
   int passed = 0;

   bit         kseq [MAXN];
   int         nseq;
   bit         s_arr [MAXN];
   bit         kc [MAXN];
   logic [7:0] obs [MAXN+1];
   logic [7:0] expv [MAXN+1];
   logic [3:0] ev_strobe [MAXN+1];
   int         ev_cnt [MAXN+1];
   int         ev_sym [MAXN+1];

   morse_key_timing #(
      .CNT_W     (8),
      .DOT_MAX   (DOT_MAX),
      .GAP_CHAR  (GAP_CHAR),
      .GAP_WORD  (GAP_WORD),
      .STUCK_MAX (STUCK_MAX),
      .DEBOUNCE  (DEBOUNCE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key       (key),
      .sym_valid (sym_valid),
      .sym       (sym),
      .sym_count (sym_count),
      .char_end  (char_end),
      .word_end  (word_end),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {sym_valid, sym, sym_count, char_end, word_end, err};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key   = 1'b0;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic clear_seq();
      nseq = 0;
   endtask

   task automatic add_run(input bit v, input int len);
      for (int i = 0; i < len; i++) begin
         if (nseq < MAXN) begin
            kseq[nseq] = v;
            nseq++;
         end
      end
   endtask

   task automatic drive_and_record();
      obs[0] = outs();
      for (int c = 0; c < nseq; c++) begin
         key = kseq[c];
         step();
         obs[c+1] = outs();
      end
      key = 1'b0;
   endtask

   // Expected outputs from the key waveform: mark/space run lengths and the gap thresholds.
   task automatic build_model();
      int n, c, a, f, len, cnt, symv;
      n = nseq;
      for (int i = 0; i <= n; i++) begin
         ev_strobe[i] = 4'b0;
         ev_cnt[i]    = -1;
         ev_sym[i]    = -1;
      end
      for (int i = 0; i < n; i++) s_arr[i] = (i >= 2) ? kseq[i-2] : 1'b0;
      for (int i = 0; i < n; i++) begin
`ifdef MORSE_KEY_DEBOUNCE_EN
         bit stable;
         stable = (i >= DEBOUNCE);
         for (int j = 2; j <= DEBOUNCE; j++)
            if (i >= DEBOUNCE && s_arr[i-j] != s_arr[i-1]) stable = 1'b0;
         kc[i] = stable ? s_arr[i-1] : ((i > 0) ? kc[i-1] : 1'b0);
`else
         kc[i] = s_arr[i];
`endif
      end

      cnt = 0;
      c   = 0;
      while (c < n) begin
         if (!kc[c]) begin
            c++;
            continue;
         end
         a = c;
         while (c < n && kc[c]) c++;
         len = c - a;
         if (len > STUCK_MAX) begin
            if (a + STUCK_MAX + 1 <= n) begin
               ev_strobe[a+STUCK_MAX+1][0] = 1'b1;
               ev_cnt[a+STUCK_MAX+1]       = 0;
            end
            cnt = 0;
         end else if (c < n) begin
            if (cnt == MAXSYM) begin
               ev_strobe[c+1][0] = 1'b1;
            end else begin
               cnt++;
               ev_strobe[c+1][3] = 1'b1;
               ev_sym[c+1]       = (len <= DOT_MAX) ? 1 : 0;
               ev_cnt[c+1]       = cnt;
            end
         end
         if (c >= n) break;
         f = c;
         while (c < n && !kc[c]) c++;
         len = c - f;
         if (len >= GAP_CHAR && cnt > 0) begin
            if (f + GAP_CHAR + 1 <= n) begin
               ev_strobe[f+GAP_CHAR+1][2] = 1'b1;
               ev_cnt[f+GAP_CHAR+1]       = 0;
            end
            cnt = 0;
         end
         if (len > GAP_WORD && f + GAP_WORD + 1 <= n) ev_strobe[f+GAP_WORD+1][1] = 1'b1;
      end

      cnt  = 0;
      symv = 0;
      for (int i = 0; i <= n; i++) begin
         if (ev_cnt[i] >= 0) cnt = ev_cnt[i];
         if (ev_sym[i] >= 0) symv = ev_sym[i];
         expv[i] = {ev_strobe[i][3], 1'(symv), 3'(cnt), ev_strobe[i][2:0]};
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (outs() !== 8'h00) $display("FAIL reset_state got=%b exp=%b", outs(), 8'h00);
      else passed++;
      key = 1'b1;
      repeat (6) step();
      reset = 1'b1;
      key   = 1'b0;
      repeat (2) begin
         step();
         checks++;
         if (outs() !== 8'h00) $display("FAIL reset_midmark got=%b exp=%b", outs(), 8'h00);
         else passed++;
      end
      reset = 1'b0;
      repeat (30) begin
         step();
         checks++;
         if (outs() !== 8'h00) $display("FAIL reset_aborted_mark got=%b exp=%b", outs(), 8'h00);
         else passed++;
      end
      clear_seq();
      add_run(0, 3); add_run(1, 3); add_run(0, 30);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL reset_then_dot cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_classify();
      do_reset();
      clear_seq();
      add_run(0, 4);
      add_run(1, 3);  add_run(0, 25);
      add_run(1, 4);  add_run(0, 25);
      add_run(1, 5);  add_run(0, 25);
      add_run(1, 1);  add_run(0, 25);
      add_run(1, 60); add_run(0, 25);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL classify cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_char_word();
      do_reset();
      clear_seq();
      add_run(0, 4);
      add_run(1, 2); add_run(0, 4);
      add_run(1, 7); add_run(0, 30);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL char_word cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_gap_boundary();
      do_reset();
      clear_seq();
      add_run(0, 4);
      add_run(1, 2); add_run(0, GAP_CHAR);
      add_run(1, 2); add_run(0, GAP_WORD);
      add_run(1, 2); add_run(0, GAP_WORD + 1);
      add_run(1, 2); add_run(0, GAP_CHAR - 1);
      add_run(1, 6); add_run(0, 30);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL gap_boundary cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_stuck();
      do_reset();
      clear_seq();
      add_run(0, 3);
      add_run(1, 70); add_run(0, 5);
      add_run(1, 2);  add_run(0, 25);
      add_run(1, STUCK_MAX + 1); add_run(0, 25);
      add_run(1, 2);  add_run(0, 3);
      add_run(1, 65); add_run(0, 25);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL stuck cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_overflow();
      do_reset();
      clear_seq();
      add_run(0, 4);
      for (int i = 0; i < 6; i++) begin
         add_run(1, 2);
         add_run(0, (i == 5) ? 30 : 2);
      end
      for (int i = 0; i < 5; i++) begin
         add_run(1, 3);
         add_run(0, (i == 4) ? 30 : 3);
      end
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL overflow cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_glitch();
      do_reset();
      clear_seq();
      add_run(0, 3);
      add_run(1, 2); add_run(0, 30);
      add_run(1, 4); add_run(0, 30);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL glitch cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   task automatic test_random();
      int r, lh, ll;
      do_reset();
      clear_seq();
      add_run(0, 5);
      repeat (40) begin
         r  = int'($urandom_range(0, 9));
         lh = (r == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(1, 8));
         ll = int'($urandom_range(1, 25));
         add_run(1, lh);
         add_run(0, ll);
      end
      add_run(0, 30);
      drive_and_record();
      build_model();
      for (int i = 0; i <= nseq; i++) begin
         checks++;
         if (obs[i] !== expv[i]) $display("FAIL random cyc=%0d got=%b exp=%b", i, obs[i], expv[i]);
         else passed++;
      end
   endtask

   initial begin
      reset = 1'b1;
      key   = 1'b0;
      test_reset();
      test_classify();
      test_char_word();
      test_gap_boundary();
      test_stuck();
      test_overflow();
      test_glitch();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
